// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes and frame-length helper.
// Used by uart_tx_cfg and the future uart_rx_cfg.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } uart_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Whole-frame duration in clock cycles; a zero divisor behaves as one.
   function automatic int frame_cycles(input int data_bits, input int parity,
                                       input int stop_bits, input int clks_per_bit);
      int n;
      n = (clks_per_bit < 1) ? 1 : clks_per_bit;
      return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * n;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable bit-period down-counter: o_Tick marks the last cycle of every bit period.
// The period is latched on i_Load and repeats automatically until the next load.
module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             i_Clock,
   input  logic             i_Reset,
   input  logic             i_Load,
   input  logic [DIV_W-1:0] i_N,
   output logic             o_Tick
);

   logic [DIV_W-1:0] r_reload;
   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] w_reload;

   // A divisor of zero gives the same one-cycle period as a divisor of one.
   assign w_reload = (i_N == '0) ? '0 : i_N - DIV_W'(1);

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_reload <= '0;
         r_cnt    <= '0;
      end else if (i_Load) begin
         r_reload <= w_reload;
         r_cnt    <= w_reload;
      end else if (r_cnt == '0) begin
         r_cnt    <= r_reload;
      end else begin
         r_cnt    <= r_cnt - DIV_W'(1);
      end
   end

   assign o_Tick = (r_cnt == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5-9 data bits, none/odd/even parity, 1-2 stop bits,
// runtime divisor, valid/ready intake. Define UART_TX_BREAK_EN to add the i_Break input.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = PAR_NONE,
   parameter int STOP_BITS = 1,
   parameter int DIV_W     = 16
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic [DIV_W-1:0]     i_Clks_Per_Bit,
   input  logic                 i_Tx_Valid,
   input  logic [DATA_BITS-1:0] i_Tx_Byte,
   output logic                 o_Tx_Ready,
   output logic                 o_Tx_Serial,
   output logic                 o_Tx_Active,
   output logic                 o_Tx_Done
`ifdef UART_TX_BREAK_EN
   ,
   input  logic                 i_Break
`endif
);

   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
   localparam logic             LAST_STOP = (STOP_BITS == 2);

   uart_state_e            r_state;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_par;
   logic [IDX_W-1:0]       r_bit_idx;
   logic                   r_stop_idx;
   logic                   r_serial;
   logic                   r_ready;
   logic                   r_active;
   logic                   r_done;
   logic                   w_accept;
   logic                   w_tick;

`ifdef UART_TX_BREAK_EN
   assign w_accept = i_Tx_Valid && r_ready && !i_Break;
`else
   assign w_accept = i_Tx_Valid && r_ready;
`endif

   uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .i_Load  (w_accept),
      .i_N     (i_Clks_Per_Bit),
      .o_Tick  (w_tick)
   );

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_state    <= S_IDLE;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
         r_serial   <= 1'b1;
         r_ready    <= 1'b1;
         r_active   <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_shift  <= i_Tx_Byte;
                  r_par    <= (PARITY == PAR_ODD) ? ~(^i_Tx_Byte) : ^i_Tx_Byte;
                  r_state  <= S_START;
                  r_serial <= 1'b0;
                  r_ready  <= 1'b0;
                  r_active <= 1'b1;
`ifdef UART_TX_BREAK_EN
               end else if (i_Break) begin
                  r_serial <= 1'b0;
                  r_ready  <= 1'b0;
`endif
               end else begin
                  r_serial <= 1'b1;
                  r_ready  <= 1'b1;
               end
            end
            S_START: begin
               if (w_tick) begin
                  r_state   <= S_DATA;
                  r_serial  <= r_shift[0];
                  r_bit_idx <= '0;
               end
            end
            S_DATA: begin
               if (w_tick) begin
                  if (r_bit_idx == LAST_IDX) begin
                     r_bit_idx <= '0;
                     if (PARITY != PAR_NONE) begin
                        r_state  <= S_PARITY;
                        r_serial <= r_par;
                     end else begin
                        r_state    <= S_STOP;
                        r_serial   <= 1'b1;
                        r_stop_idx <= 1'b0;
                     end
                  end else begin
                     r_bit_idx <= r_bit_idx + IDX_W'(1);
                     r_shift   <= r_shift >> 1;
                     r_serial  <= r_shift[1];
                  end
               end
            end
            S_PARITY: begin
               if (w_tick) begin
                  r_state    <= S_STOP;
                  r_serial   <= 1'b1;
                  r_stop_idx <= 1'b0;
               end
            end
            S_STOP: begin
               // Done and Ready rise together so a waiting byte starts after one idle cycle.
               if (w_tick) begin
                  if (r_stop_idx == LAST_STOP) begin
                     r_state    <= S_IDLE;
                     r_stop_idx <= 1'b0;
                     r_done     <= 1'b1;
                     r_ready    <= 1'b1;
                     r_active   <= 1'b0;
                  end else begin
                     r_stop_idx <= 1'b1;
                  end
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_serial <= 1'b1;
               r_ready  <= 1'b1;
               r_active <= 1'b0;
            end
         endcase
      end
   end

   assign o_Tx_Ready  = r_ready;
   assign o_Tx_Serial = r_serial;
   assign o_Tx_Active = r_active;
   assign o_Tx_Done   = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three frame configurations against a frame-level reference model.
module tb_uart_tx_cfg;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  valid;
   logic [2:0]  brk;
   logic [8:0]  tx_byte [3];
   logic [15:0] cpb [3];
   logic [2:0]  ready, serial, active, done;

   int DB  [3] = '{8, 8, 7};
   int PAR [3] = '{0, 2, 1};
   int SB  [3] = '{1, 1, 2};

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   uart_tx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16)) u_dut_a (
      .i_Clock(clk), .i_Reset(rst), .i_Clks_Per_Bit(cpb[0]), .i_Tx_Valid(valid[0]),
      .i_Tx_Byte(tx_byte[0][7:0]), .o_Tx_Ready(ready[0]), .o_Tx_Serial(serial[0]),
      .o_Tx_Active(active[0]), .o_Tx_Done(done[0])
`ifdef UART_TX_BREAK_EN
      , .i_Break(brk[0])
`endif
   );

   uart_tx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV_W(16)) u_dut_b (
      .i_Clock(clk), .i_Reset(rst), .i_Clks_Per_Bit(cpb[1]), .i_Tx_Valid(valid[1]),
      .i_Tx_Byte(tx_byte[1][7:0]), .o_Tx_Ready(ready[1]), .o_Tx_Serial(serial[1]),
      .o_Tx_Active(active[1]), .o_Tx_Done(done[1])
`ifdef UART_TX_BREAK_EN
      , .i_Break(brk[1])
`endif
   );

   uart_tx_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .DIV_W(16)) u_dut_c (
      .i_Clock(clk), .i_Reset(rst), .i_Clks_Per_Bit(cpb[2]), .i_Tx_Valid(valid[2]),
      .i_Tx_Byte(tx_byte[2][6:0]), .o_Tx_Ready(ready[2]), .o_Tx_Serial(serial[2]),
      .o_Tx_Active(active[2]), .o_Tx_Done(done[2])
`ifdef UART_TX_BREAK_EN
      , .i_Break(brk[2])
`endif
   );

   // Reference model: a frame is a list of line levels, each held n cycles.
   logic [3:0] exp_o [3];   // {serial, ready, active, done}
   bit         m_busy [3];
   int         m_t [3];
   int         m_len [3];
   int         m_n [3];
   logic       m_bits [3][16];

   always @(posedge clk) begin : model
      logic bk;
      logic p;
      int   nb;
      for (int k = 0; k < 3; k++) begin
         bk = 1'b0;
`ifdef UART_TX_BREAK_EN
         bk = brk[k];
`endif
         if (rst) begin
            m_busy[k] = 1'b0;
            exp_o[k]  = 4'b1100;
         end else if (m_busy[k]) begin
            m_t[k] = m_t[k] + 1;
            if (m_t[k] == m_len[k]) begin
               m_busy[k] = 1'b0;
               exp_o[k]  = 4'b1101;
            end else begin
               exp_o[k] = {m_bits[k][m_t[k] / m_n[k]], 3'b010};
            end
         end else if (valid[k] && exp_o[k][2] && !bk) begin
            m_n[k] = (cpb[k] == 16'd0) ? 1 : int'(cpb[k]);
            nb = 0;
            m_bits[k][nb] = 1'b0; nb = nb + 1;
            p = 1'b0;
            for (int i = 0; i < DB[k]; i++) begin
               m_bits[k][nb] = tx_byte[k][i];
               p = p ^ tx_byte[k][i];
               nb = nb + 1;
            end
            if (PAR[k] != 0) begin
               m_bits[k][nb] = (PAR[k] == 2) ? p : ~p;
               nb = nb + 1;
            end
            for (int s = 0; s < SB[k]; s++) begin
               m_bits[k][nb] = 1'b1;
               nb = nb + 1;
            end
            m_len[k]  = nb * m_n[k];
            m_t[k]    = 0;
            m_busy[k] = 1'b1;
            exp_o[k]  = 4'b0010;
         end else if (bk) begin
            exp_o[k] = 4'b0000;
         end else begin
            exp_o[k] = 4'b1100;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            tests++;
            if ({serial[k], ready[k], active[k], done[k]} !== exp_o[k]) begin
               fails++;
               $display("FAIL model_dut%0d at %0t: serial/ready/active/done got %b want %b",
                        k, $time, {serial[k], ready[k], active[k], done[k]}, exp_o[k]);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Send one byte on instance k and record the line level at the start of each bit period.
   task automatic send_cap(input int k, input logic [8:0] b, input logic [15:0] n,
                           input int change_at, input logic [15:0] n2,
                           output int alen, output logic [15:0] bits,
                           output int dones, output int rdy_at_done);
      int  nn;
      bit  seen;
      bit  fin;
      nn = (n == 16'd0) ? 1 : int'(n);
      alen = 0; bits = '0; dones = 0; rdy_at_done = 0; seen = 1'b0; fin = 1'b0;
      @(negedge clk);
      tx_byte[k] = b; cpb[k] = n; valid[k] = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (active[k]) begin
            if (!seen) begin
               valid[k] = 1'b0;
               seen = 1'b1;
            end
            if (alen % nn == 0) bits[alen / nn] = serial[k];
            alen++;
            if (alen == change_at) cpb[k] = n2;
         end
         if (done[k]) begin
            dones++;
            rdy_at_done = int'(ready[k]);
         end
         if (seen && !active[k] && !done[k]) begin
            fin = 1'b1;
            break;
         end
      end
      valid[k] = 1'b0;
      check("send_finished", int'(fin), 1);
   endtask

   initial begin
      int alen, dones, rdy, t1, t2, s2, dcount, lowc, actc;
      logic [15:0] bits;
      bit prev_act, got;

      rst = 1'b1; valid = '0; brk = '0;
      for (int k = 0; k < 3; k++) begin
         tx_byte[k] = '0;
         cpb[k] = 16'd4;
      end
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      for (int k = 0; k < 3; k++)
         check($sformatf("reset_state_dut%0d", k), int'({serial[k], ready[k], active[k], done[k]}), 12);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 8N1, N=4, 0xA5
      send_cap(0, 9'h0A5, 16'd4, -1, 16'd4, alen, bits, dones, rdy);
      check("a5_len", alen, 40);
      check("a5_bits", int'(bits), 16'h034A);
      check("a5_done_count", dones, 1);
      check("a5_ready_in_done", rdy, 1);

      // Parity: even 8 bits then odd 7 bits, byte 0x07, N=3
      send_cap(1, 9'h007, 16'd3, -1, 16'd3, alen, bits, dones, rdy);
      check("even_len", alen, 33);
      check("even_parity_bit", int'(bits[9]), 1);
      send_cap(2, 9'h007, 16'd3, -1, 16'd3, alen, bits, dones, rdy);
      check("odd_len", alen, 33);
      check("odd_parity_bit", int'(bits[8]), 0);

      // Divisor 0, then mid-frame divisor change
      send_cap(0, 9'h033, 16'd0, -1, 16'd0, alen, bits, dones, rdy);
      check("div0_len", alen, 10);
      send_cap(0, 9'h0F0, 16'd4, 5, 16'd8, alen, bits, dones, rdy);
      check("div_change_len", alen, 40);
      send_cap(0, 9'h00F, 16'd8, -1, 16'd8, alen, bits, dones, rdy);
      check("div_next_len", alen, 80);

      // Back-to-back frames on the 7-bit, 2-stop instance, N=2
      @(negedge clk);
      cpb[2] = 16'd2; tx_byte[2] = 9'h055; valid[2] = 1'b1;
      t1 = -1; t2 = -1; s2 = -1; prev_act = 1'b0;
      for (int c = 0; c < 200 && t2 < 0; c++) begin
         @(negedge clk);
         if (active[2] && !prev_act) begin
            if (t1 < 0) begin
               t1 = c;
               tx_byte[2] = 9'h02A;
            end else begin
               t2 = c;
               s2 = int'(serial[2]);
               valid[2] = 1'b0;
            end
         end
         prev_act = active[2];
      end
      valid[2] = 1'b0;
      check("b2b_start_spacing", t2 - t1, 23);
      check("b2b_second_start_low", s2, 0);
      repeat (30) @(negedge clk);

      // Reset during data bit 3
      @(negedge clk);
      cpb[0] = 16'd4; tx_byte[0] = 9'h05A; valid[0] = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (active[0]) begin
            got = 1'b1;
            break;
         end
      end
      valid[0] = 1'b0;
      check("rst_frame_started", int'(got), 1);
      repeat (17) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_frame_outputs", int'({serial[0], ready[0], active[0], done[0]}), 12);
      dcount = 0;
      repeat (45) begin
         @(negedge clk);
         if (done[0]) dcount++;
      end
      check("rst_no_done", dcount, 0);
      send_cap(0, 9'h03C, 16'd2, -1, 16'd2, alen, bits, dones, rdy);
      check("after_rst_len", alen, 20);
      check("after_rst_done", dones, 1);

`ifdef UART_TX_BREAK_EN
      @(negedge clk);
      cpb[0] = 16'd3; tx_byte[0] = 9'h0C3; brk[0] = 1'b1; valid[0] = 1'b1;
      lowc = 0; actc = 0;
      repeat (50) begin
         @(negedge clk);
         if (serial[0] == 1'b0) lowc++;
         if (active[0]) actc++;
      end
      check("brk_line_low", lowc, 50);
      check("brk_no_accept", actc, 0);
      brk[0] = 1'b0;
      @(negedge clk);
      check("brk_release", int'({serial[0], ready[0], active[0]}), 6);
      @(negedge clk);
      check("brk_then_accept", int'(active[0]), 1);
      valid[0] = 1'b0;
      repeat (40) @(negedge clk);
`else
      lowc = 0; actc = 0;
`endif

      // Randomized traffic on all three instances
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 699) == 0);
         for (int k = 0; k < 3; k++) begin
            valid[k]   = ($urandom_range(0, 3) != 0);
            tx_byte[k] = 9'($urandom);
            cpb[k]     = 16'($urandom_range(0, 4));
`ifdef UART_TX_BREAK_EN
            if ($urandom_range(0, 59) == 0) brk[k] = ~brk[k];
`endif
         end
      end
      rst = 1'b0; valid = '0; brk = '0;
      repeat (150) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
